// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter: data width, frame
// length and the serializer state encoding.
package uart_tx_fifo_pkg;

   localparam int DATA_W     = 8;
   localparam int FRAME_BITS = 10;

   typedef logic [1:0] uart_state_t;

   localparam uart_state_t ST_IDLE  = 2'd0;
   localparam uart_state_t ST_START = 2'd1;
   localparam uart_state_t ST_DATA  = 2'd2;
   localparam uart_state_t ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output and registered
// full/empty/level flags.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;
   logic [AW:0]      level_nxt;

   // A push while full still lands if the same edge frees a slot.
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign dout    = mem[rd_ptr];

   always_comb begin
      level_nxt = level;
      if (push_ok && !pop_ok) begin
         level_nxt = level + LVL_ONE;
      end else if (pop_ok && !push_ok) begin
         level_nxt = level - LVL_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
         level <= level_nxt;
         full  <= (level_nxt == LVL_FULL);
         empty <= (level_nxt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a start/data/stop
// serializer with a registered TXD output.
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int CLK_FREQ   = 50000000,
   parameter int UART_BPS   = 115200,
   parameter int FIFO_DEPTH = 16,
   localparam int ADDR_W    = $clog2(FIFO_DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   level,
   output logic              ovf,
   output logic              uart_tx_busy,
   output logic              uart_txd
);

   localparam int BPS_CNT = CLK_FREQ / UART_BPS;
   localparam int CNT_W   = $clog2(BPS_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   uart_state_t       state;
   logic [CNT_W-1:0]  baud_cnt;
   logic [2:0]        bit_idx;
   logic [DATA_W-1:0] shift;
   logic [DATA_W-1:0] fifo_dout;
   logic              txd_q;
   logic              baud_end;
   logic              pop;

   // Handshake: wr_en is a one-cycle push request with no backpressure; it is
   // accepted when the FIFO has room or pops on the same edge, else dropped
   // and flagged on ovf one cycle later.
   assign baud_end     = (baud_cnt == CNT_MAX);
   assign pop          = !empty && ((state == ST_IDLE) || (state == ST_STOP && baud_end));
   assign uart_tx_busy = (state != ST_IDLE);
   assign uart_txd     = txd_q;

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (wr_en),
      .pop   (pop),
      .din   (wr_data),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
      end else begin
         if (pop) shift <= fifo_dout;
         case (state)
            ST_IDLE: begin
               baud_cnt <= '0;
               if (pop) state <= ST_START;
            end
            ST_START: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= ST_DATA;
               end else begin
                  baud_cnt <= baud_cnt + CNT_ONE;
               end
            end
            ST_DATA: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) state <= ST_STOP;
                  else                 bit_idx <= bit_idx + 3'd1;
               end else begin
                  baud_cnt <= baud_cnt + CNT_ONE;
               end
            end
            ST_STOP: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  state    <= pop ? ST_START : ST_IDLE;
               end else begin
                  baud_cnt <= baud_cnt + CNT_ONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // The line follows the state one clock late, so every bit still lasts BPS_CNT clocks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txd_q <= 1'b1;
         ovf   <= 1'b0;
      end else begin
         ovf <= wr_en && full && !pop;
         case (state)
            ST_START: txd_q <= 1'b0;
            ST_DATA:  txd_q <= shift[bit_idx];
            default:  txd_q <= 1'b1;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: frame-level reference model, line
// decoder and directed plus random write scenarios.
module tb_uart_tx_fifo;

   localparam int CLK_FREQ   = 1000000;
   localparam int UART_BPS   = 100000;
   localparam int BPS        = CLK_FREQ / UART_BPS;
   localparam int FRAME_CLKS = 10 * BPS;
   localparam int DEPTH      = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full, empty, ovf, uart_tx_busy, uart_txd;
   logic [4:0] level;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // reference model state
   logic [7:0] m_q[$];
   logic [7:0] exp_q[$];
   bit         m_busy = 1'b0, f_valid = 1'b0, m_ovf = 1'b0, pop_now, has_room;
   int         m_end = 0, f_start = 0, n_pops = 0;
   logic [7:0] f_byte = 8'h00;

   // observation counters
   int ovf_cnt = 0, busy_cnt = 0, rx_total = 0;
   logic [4:0] level_peak = '0;

   // decoder state
   bit         rx_active = 1'b0, rx_prev = 1'b1;
   int         rx_cnt = 0, rx_k;
   logic [7:0] rx_byte = 8'h00;

   uart_tx_fifo #(
      .CLK_FREQ   (CLK_FREQ),
      .UART_BPS   (UART_BPS),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .full         (full),
      .empty        (empty),
      .level        (level),
      .ovf          (ovf),
      .uart_tx_busy (uart_tx_busy),
      .uart_txd     (uart_txd)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Expected line level after the most recent edge, from the frame start time.
   function automatic logic exp_txd();
      int d, k;
      if (!f_valid) return 1'b1;
      d = cyc - f_start - 1;
      if (d < 0 || d >= FRAME_CLKS) return 1'b1;
      k = d / BPS;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return f_byte[k-1];
   endfunction

   // Model: a frame occupies FRAME_CLKS clocks from its pop; pops happen
   // whenever the transmitter is free and bytes are waiting.
   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         m_q.delete();
         exp_q.delete();
         m_busy  = 1'b0;
         f_valid = 1'b0;
         m_ovf   = 1'b0;
      end else begin
         if (m_busy && cyc == m_end) m_busy = 1'b0;
         has_room = (m_q.size() < DEPTH);
         pop_now  = !m_busy && (m_q.size() != 0);
         if (pop_now) begin
            f_byte  = m_q.pop_front();
            f_start = cyc;
            f_valid = 1'b1;
            m_busy  = 1'b1;
            m_end   = cyc + FRAME_CLKS;
            exp_q.push_back(f_byte);
            n_pops++;
         end
         m_ovf = 1'b0;
         if (wr_en) begin
            if (has_room || pop_now) m_q.push_back(wr_data);
            else                     m_ovf = 1'b1;
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      check_eq("level", level, m_q.size());
      check_eq("full", full, m_q.size() == DEPTH);
      check_eq("empty", empty, m_q.size() == 0);
      check_eq("ovf", ovf, m_ovf);
      check_eq("busy", uart_tx_busy, m_busy);
      check_eq("txd", uart_txd, exp_txd());
      if (ovf === 1'b1) ovf_cnt++;
      if (uart_tx_busy === 1'b1) busy_cnt++;
      if (level > level_peak) level_peak = level;
   end

   // Line decoder: mid-bit sampling, bytes compared in order against exp_q.
   always @(negedge clk) begin
      if (!rst_n) begin
         rx_active = 1'b0;
         rx_prev   = 1'b1;
      end else begin
         if (rx_active) begin
            rx_cnt++;
            if (rx_cnt % BPS == BPS / 2) begin
               rx_k = rx_cnt / BPS;
               if (rx_k >= 1 && rx_k <= 8) rx_byte[rx_k-1] = uart_txd;
               if (rx_k == 9) begin
                  check_eq("rx_stop", uart_txd, 1'b1);
                  check_eq("rx_expected", exp_q.size() != 0, 1'b1);
                  if (exp_q.size() != 0) check_eq("rx_byte", rx_byte, exp_q.pop_front());
                  rx_total++;
                  rx_active = 1'b0;
               end
            end
         end else if (rx_prev && !uart_txd) begin
            rx_active = 1'b1;
            rx_cnt    = 0;
         end
         rx_prev = uart_txd;
      end
   end

   task automatic drive(input logic en, input logic [7:0] d);
      wr_en   = en;
      wr_data = d;
      @(negedge clk);
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n = 0;
      while (!(empty && !uart_tx_busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, n < budget, 1'b1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int n0, low_cnt, rx_before;
      rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
      repeat (3) @(negedge clk);
      check_eq("rst_txd", uart_txd, 1'b1);
      check_eq("rst_busy", uart_tx_busy, 1'b0);
      check_eq("rst_full", full, 1'b0);
      check_eq("rst_empty", empty, 1'b1);
      check_eq("rst_level", level, 0);
      check_eq("rst_ovf", ovf, 1'b0);
      #2 rst_n = 1'b1;
      @(negedge clk);

      // single byte latency and duration
      busy_cnt = 0;
      drive(1'b1, 8'hA5);
      check_eq("s1_empty", empty, 1'b0);
      check_eq("s1_level", level, 1);
      drive(1'b0, 8'h00);
      check_eq("s1_txd_n1", uart_txd, 1'b1);
      check_eq("s1_busy_n1", uart_tx_busy, 1'b1);
      @(negedge clk);
      check_eq("s1_txd_n2", uart_txd, 1'b0);
      wait_idle(300, "s1_idle");
      check_eq("s1_busy_len", busy_cnt, FRAME_CLKS);

      // burst of three back-to-back frames
      level_peak = '0;
      busy_cnt   = 0;
      drive(1'b1, 8'h00);
      drive(1'b1, 8'hFF);
      drive(1'b1, 8'h55);
      drive(1'b0, 8'h00);
      wait_idle(600, "s2_idle");
      check_eq("s2_peak", level_peak, 2);
      check_eq("s2_busy_len", busy_cnt, 3 * FRAME_CLKS);

      // fill during a frame, overflow, then push on the STOP-end pop
      ovf_cnt = 0;
      n0 = cyc + 1;
      for (int i = 0; i < 17; i++) drive(1'b1, 8'h80 + 8'(i));
      check_eq("s3_full", full, 1'b1);
      check_eq("s3_level", level, 16);
      drive(1'b1, 8'hEE);
      check_eq("s3_ovf_pulse", ovf, 1'b1);
      check_eq("s3_level_drop", level, 16);
      drive(1'b0, 8'h00);
      check_eq("s3_ovf_gone", ovf, 1'b0);
      while (cyc < n0 + FRAME_CLKS) @(negedge clk);
      drive(1'b1, 8'h91);
      check_eq("s3_pushpop_level", level, 16);
      check_eq("s3_pushpop_ovf", ovf, 1'b0);
      drive(1'b0, 8'h00);
      wait_idle(20 * FRAME_CLKS, "s3_idle");
      check_eq("s3_ovf_count", ovf_cnt, 1);

      // reset in the middle of data bit 3
      n0 = cyc + 1;
      drive(1'b1, 8'h3C);
      drive(1'b0, 8'h00);
      while (cyc < n0 + 1 + 45) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("s4_txd", uart_txd, 1'b1);
      check_eq("s4_busy", uart_tx_busy, 1'b0);
      check_eq("s4_empty", empty, 1'b1);
      check_eq("s4_level", level, 0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      low_cnt = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (uart_txd !== 1'b1) low_cnt++;
      end
      check_eq("s4_quiet", low_cnt, 0);

      // pointer wrap: 40 spaced bytes
      ovf_cnt   = 0;
      rx_before = rx_total;
      for (int i = 0; i < 40; i++) begin
         drive(1'b1, 8'(i));
         drive(1'b0, 8'h00);
         repeat (118) @(negedge clk);
      end
      wait_idle(300, "s5_idle");
      check_eq("s5_ovf_count", ovf_cnt, 0);
      check_eq("s5_rx_count", rx_total - rx_before, 40);

      // random bursts with random gaps
      for (int i = 0; i < 50; i++) begin
         drive(1'b1, 8'($urandom_range(0, 255)));
         wr_en = 1'b0;
         repeat ($urandom_range(0, 30)) @(negedge clk);
      end
      drive(1'b0, 8'h00);
      wait_idle(60 * FRAME_CLKS, "s6_idle");

      check_eq("rx_drained", exp_q.size(), 0);
      check_eq("rx_total", rx_total, n_pops - 1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
